// File: rtl/rst_seq.sv
// rtl/rst_seq.sv - reset sequencer: ENIR tick train, staged reset release, soft reset
module rst_seq #(
  parameter int PRESCALE  = 4000,
  parameter int STAGES    = 3,
  parameter int STAGE_GAP = 8,
  parameter int SRST_HOLD = 16
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              IR_N,
  input  logic              SRST_REQ,
  output logic              ENIR,
  output logic [STAGES-1:0] RST_STG_N,
  output logic              BUSY,
  output logic              SRST_ACK
);

  localparam int PRE_W  = $clog2(PRESCALE);
  localparam int GAP_W  = $clog2(STAGE_GAP + 1);
  localparam int HOLD_W = $clog2(SRST_HOLD + 1);
  localparam int IDX_W  = (STAGES > 1) ? $clog2(STAGES) : 1;

  localparam logic [PRE_W-1:0]  PRE_TC  = PRE_W'(PRESCALE - 1);
  localparam logic [GAP_W-1:0]  GAP_TC  = GAP_W'(STAGE_GAP - 1);
  localparam logic [HOLD_W-1:0] HOLD_TC = HOLD_W'(SRST_HOLD - 1);
  localparam logic [IDX_W-1:0]  IDX_TC  = IDX_W'(STAGES - 1);
  localparam logic [STAGES-1:0] STG_ONE = STAGES'(1);

  typedef enum logic [1:0] {WAIT_IR, RELEASE, RUN, SOFT} state_t;

  state_t              state_q, state_d;
  logic [PRE_W-1:0]    pre_q, pre_d;
  logic [GAP_W-1:0]    gap_q, gap_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [STAGES-1:0]   stg_q, stg_d;
  logic                enir_q, enir_d;
  logic                ack_q, ack_d;
  logic                ir_meta_q, ir_s_q;
  logic                req_q;

  // IR_N crosses from the generator's domain; SRST_REQ gets one register stage.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      ir_meta_q <= 1'b0;
      ir_s_q    <= 1'b0;
      req_q     <= 1'b0;
    end else begin
      ir_meta_q <= IR_N;
      ir_s_q    <= ir_meta_q;
      req_q     <= SRST_REQ;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= WAIT_IR;
      pre_q   <= '0;
      gap_q   <= '0;
      hold_q  <= '0;
      idx_q   <= '0;
      stg_q   <= '0;
      enir_q  <= 1'b0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pre_q   <= pre_d;
      gap_q   <= gap_d;
      hold_q  <= hold_d;
      idx_q   <= idx_d;
      stg_q   <= stg_d;
      enir_q  <= enir_d;
      ack_q   <= ack_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pre_d   = pre_q;
    gap_d   = gap_q;
    hold_d  = hold_q;
    idx_d   = idx_q;
    stg_d   = stg_q;
    enir_d  = 1'b0;
    ack_d   = 1'b0;
    // Loss of the internal reset overrides everything, including a soft reset in flight.
    if (!ir_s_q && state_q != WAIT_IR) begin
      state_d = WAIT_IR;
      pre_d   = '0;
      gap_d   = '0;
      hold_d  = '0;
      idx_d   = '0;
      stg_d   = '0;
    end else begin
      case (state_q)
        WAIT_IR: begin
          stg_d = '0;
          if (ir_s_q) begin
            state_d = RELEASE;
            pre_d   = '0;
            gap_d   = '0;
            idx_d   = '0;
          end else if (pre_q == PRE_TC) begin
            pre_d  = '0;
            enir_d = 1'b1;
          end else begin
            pre_d = pre_q + 1'b1;
          end
        end
        RELEASE: begin
          if (gap_q == GAP_TC) begin
            gap_d = '0;
            stg_d = stg_q | (STG_ONE << idx_q);
            if (idx_q == IDX_TC) begin
              state_d = RUN;
              idx_d   = '0;
            end else begin
              idx_d = idx_q + 1'b1;
            end
          end else begin
            gap_d = gap_q + 1'b1;
          end
        end
        RUN: begin
          if (req_q) begin
            state_d = SOFT;
            stg_d   = '0;
            ack_d   = 1'b1;
            hold_d  = '0;
          end
        end
        SOFT: begin
          if (hold_q == HOLD_TC) begin
            state_d = RELEASE;
            hold_d  = '0;
            gap_d   = '0;
            idx_d   = '0;
          end else begin
            hold_d = hold_q + 1'b1;
          end
        end
        default: state_d = WAIT_IR;
      endcase
    end
  end

  assign ENIR      = enir_q;
  assign RST_STG_N = stg_q;
  assign SRST_ACK  = ack_q;
  // Every stage is released only in RUN, so BUSY follows the stage vector directly.
  assign BUSY      = ~&stg_q;

endmodule

// File: tb/tb_rst_seq.sv
// tb/tb_rst_seq.sv - randomized bench for rst_seq against a timestamp-based reference model
module tb_rst_seq;
  localparam int P = 4;
  localparam int S = 3;
  localparam int G = 2;
  localparam int H = 5;

  logic         CLK = 1'b0;
  logic         RST_N = 1'b0;
  logic         IR_N = 1'b0;
  logic         SRST_REQ = 1'b0;
  logic         ENIR;
  logic [S-1:0] RST_STG_N;
  logic         BUSY;
  logic         SRST_ACK;

  int compared = 0;
  int mismatched = 0;

  // Reference model: edge count since reset and the edge at which the current release sequence began.
  int n, rel_start, wait_start;
  bit in_wait, ir_h1, ir_h2, req_h1, exp_enir, exp_ack;

  rst_seq #(.PRESCALE(P), .STAGES(S), .STAGE_GAP(G), .SRST_HOLD(H)) dut (
    .CLK(CLK), .RST_N(RST_N), .IR_N(IR_N), .SRST_REQ(SRST_REQ),
    .ENIR(ENIR), .RST_STG_N(RST_STG_N), .BUSY(BUSY), .SRST_ACK(SRST_ACK)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    if (obs !== exp) begin
      mismatched++;
      $display("FAIL %s at edge %0d: got %0h expected %0h", tag, n, obs, exp);
    end
  endtask

  task automatic model_reset();
    n = 0; in_wait = 1; wait_start = 0; rel_start = 0;
    ir_h1 = 0; ir_h2 = 0; req_h1 = 0; exp_enir = 0; exp_ack = 0;
  endtask

  task automatic model_edge();
    bit irs, req;
    n = n + 1;
    irs = ir_h2;
    req = req_h1;
    exp_enir = 0;
    exp_ack = 0;
    if (in_wait) begin
      if (irs) begin
        in_wait = 0;
        rel_start = n;
      end else if ((n - wait_start) % P == 0) begin
        exp_enir = 1;
      end
    end else if (!irs) begin
      in_wait = 1;
      wait_start = n;
    end else if (req && (n - 1) >= rel_start + S * G) begin
      rel_start = n + H;
      exp_ack = 1;
    end
    ir_h2 = ir_h1;
    ir_h1 = IR_N;
    req_h1 = SRST_REQ;
  endtask

  task automatic compare_outputs();
    int r;
    r = 0;
    if (!in_wait && n >= rel_start) begin
      r = (n - rel_start) / G;
      if (r > S) r = S;
    end
    check("ENIR", 32'(ENIR), 32'(exp_enir));
    check("RST_STG_N", 32'(RST_STG_N), 32'((1 << r) - 1));
    check("BUSY", 32'(BUSY), 32'(r < S));
    check("SRST_ACK", 32'(SRST_ACK), 32'(exp_ack));
  endtask

  task automatic cycle();
    @(posedge CLK);
    model_edge();
    @(negedge CLK);
    compare_outputs();
  endtask

  task automatic async_reset();
    #2 RST_N = 1'b0;
    #1;
    check("async_stg", 32'(RST_STG_N), 32'd0);
    check("async_busy", 32'(BUSY), 32'd1);
    check("async_enir", 32'(ENIR), 32'd0);
    check("async_ack", 32'(SRST_ACK), 32'd0);
    #1 RST_N = 1'b1;
    model_reset();
  endtask

  initial begin
    model_reset();
    repeat (3) @(negedge CLK);
    check("rst_stg", 32'(RST_STG_N), 32'd0);
    check("rst_busy", 32'(BUSY), 32'd1);
    check("rst_enir", 32'(ENIR), 32'd0);
    check("rst_ack", 32'(SRST_ACK), 32'd0);
    RST_N = 1'b1;

    // Directed timeline; inputs set here are sampled at edge n+1.
    for (int i = 0; i < 170; i++) begin
      cycle();
      case (n)
        4:   check("enir_first", 32'(ENIR), 32'd1);
        5:   check("enir_width", 32'(ENIR), 32'd0);
        16:  check("enir_16", 32'(ENIR), 32'd1);
        25:  check("rel_s0", 32'(RST_STG_N), 32'd1);
        27:  check("rel_s1", 32'(RST_STG_N), 32'd3);
        28:  check("busy_28", 32'(BUSY), 32'd1);
        29:  begin
               check("rel_s2", 32'(RST_STG_N), 32'd7);
               check("busy_fall", 32'(BUSY), 32'd0);
             end
        41:  begin
               check("soft_ack", 32'(SRST_ACK), 32'd1);
               check("soft_stg", 32'(RST_STG_N), 32'd0);
             end
        42:  check("soft_ack_end", 32'(SRST_ACK), 32'd0);
        48:  check("soft_s0", 32'(RST_STG_N), 32'd1);
        52:  check("soft_s2", 32'(RST_STG_N), 32'd7);
        71:  check("held_ack1", 32'(SRST_ACK), 32'd1);
        83:  check("held_ack2", 32'(SRST_ACK), 32'd1);
        121: check("irfall_stg", 32'(RST_STG_N), 32'd0);
        125: check("enir_resume", 32'(ENIR), 32'd1);
        145: check("rerel_s0", 32'(RST_STG_N), 32'd1);
        default: ;
      endcase
      IR_N = ((n + 1 >= 21 && n + 1 <= 118) || n + 1 >= 141);
      SRST_REQ = (n + 1 == 40) || (n + 1 >= 70 && n + 1 <= 90) || (n + 1 == 110);
    end
    async_reset();

    for (int i = 0; i < 1500; i++) begin
      cycle();
      if (IR_N) IR_N = ($urandom_range(0, 99) >= 1);
      else      IR_N = ($urandom_range(0, 14) == 0);
      SRST_REQ = ($urandom_range(0, 99) < 15);
      if ($urandom_range(0, 399) == 0) async_reset();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
